// File: rtl/snic_tcp_pkg.sv
// SuperNIC TCP shim shared definitions: widths, header byte offsets,
// protocol constants, FSM state types and byte-level helper functions.
package snic_tcp_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;

  localparam int OFF_DST_MAC = 0;
  localparam int OFF_SRC_MAC = 6;
  localparam int OFF_ETYPE   = 12;
  localparam int OFF_VER_IHL = 14;
  localparam int OFF_TTL     = 22;
  localparam int OFF_PROTO   = 23;
  localparam int OFF_SIP     = 26;
  localparam int OFF_DIP     = 30;
  localparam int OFF_SPORT   = 34;
  localparam int OFF_DPORT   = 36;
  localparam int OFF_SEQ     = 38;
  localparam int OFF_ACK     = 42;
  localparam int OFF_DOFF    = 46;
  localparam int OFF_FLAGS   = 47;
  localparam int OFF_WIN     = 48;

  localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL        = 8'h45;
  localparam logic [7:0]  IP_TTL            = 8'h40;
  localparam logic [7:0]  IP_PROTO_TCP      = 8'h06;
  localparam logic [7:0]  TCP_DOFF          = 8'h50;
  localparam logic [7:0]  TCP_FLAGS_PSH_ACK = 8'h18;
  localparam logic [15:0] TCP_WIN           = 16'hFFFF;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HDR,
    TX_PAY
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_FWD,
    RX_DROP
  } rx_state_t;

  function automatic logic [6:0] popcount64(input logic [63:0] k);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + 7'(k[i]);
    end
    return c;
  endfunction

  // Write the n low bytes of v at byte offset off, most significant first.
  function automatic logic [DATA_W-1:0] put_be(
    input logic [DATA_W-1:0] d,
    input int                off,
    input int                n,
    input logic [47:0]       v
  );
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < n; i++) begin
      r[8*(off+i) +: 8] = v[8*(n-1-i) +: 8];
    end
    return r;
  endfunction

  // Read n (<=4) bytes at byte offset off as a big-endian value.
  function automatic logic [31:0] get_be(
    input logic [DATA_W-1:0] d,
    input int                off,
    input int                n
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[23:0], d[8*(off+i) +: 8]};
    end
    return r;
  endfunction

endpackage

// File: rtl/snic_tcp_design_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Ports: push_* write side (ready = not full), pop_* read side (valid = not empty).
module snic_axis_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] push_data,
  input  logic         push_valid,
  output logic         push_ready,
  output logic [W-1:0] pop_data,
  output logic         pop_valid,
  input  logic         pop_ready
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign push  = push_valid && !full;
  assign pop   = pop_ready && !empty;

  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/snic_tcp_design.sv
// SuperNIC TCP shim: TX prepends an Eth/IPv4/TCP header flit to endpoint
// packets; RX filters network packets, strips the header and forwards
// payload to the endpoint. AXI4 master is parked idle.
// Ports: endpoint->TX AXIS in, TX->MAC AXIS out, MAC->RX AXIS in,
// RX->endpoint AXIS out, AXI4 master (constant idle).
module snic_tcp_design
  import snic_tcp_pkg::*;
#(
  parameter int          FIFO_AW  = 3,
  parameter logic [47:0] LOC_MAC  = 48'h000A35000001,
  parameter logic [47:0] REM_MAC  = 48'h000A35000002,
  parameter logic [31:0] LOC_IP   = 32'h0A000001,
  parameter logic [31:0] REM_IP   = 32'h0A000002,
  parameter logic [15:0] LOC_PORT = 16'd5001,
  parameter logic [15:0] REM_PORT = 16'd5002,
  parameter logic [31:0] INIT_SEQ = 32'h0
) (
  input  logic              clk_250mhz,
  input  logic              clk_250mhz_rst,
  input  logic [DATA_W-1:0] s_axis_net_rx_from_endpoint_tdata,
  input  logic [KEEP_W-1:0] s_axis_net_rx_from_endpoint_tkeep,
  input  logic              s_axis_net_rx_from_endpoint_tlast,
  input  logic              s_axis_net_rx_from_endpoint_tvalid,
  output logic              s_axis_net_rx_from_endpoint_tready,
  output logic [DATA_W-1:0] m_axis_net_tx_tdata,
  output logic [KEEP_W-1:0] m_axis_net_tx_tkeep,
  output logic              m_axis_net_tx_tlast,
  output logic              m_axis_net_tx_tvalid,
  output logic              m_axis_net_tx_tdest,
  input  logic              m_axis_net_tx_tready,
  input  logic [DATA_W-1:0] s_axis_net_rx_tdata,
  input  logic [KEEP_W-1:0] s_axis_net_rx_tkeep,
  input  logic              s_axis_net_rx_tlast,
  input  logic              s_axis_net_rx_tvalid,
  output logic              s_axis_net_rx_tready,
  output logic [DATA_W-1:0] m_axis_net_tx_to_endpoint_tdata,
  output logic [KEEP_W-1:0] m_axis_net_tx_to_endpoint_tkeep,
  output logic              m_axis_net_tx_to_endpoint_tlast,
  output logic              m_axis_net_tx_to_endpoint_tvalid,
  output logic              m_axis_net_tx_to_endpoint_tdest,
  input  logic              m_axis_net_tx_to_endpoint_tready,
  output logic [0:0]        m_axi_awid,
  output logic [31:0]       m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [KEEP_W-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic              m_axi_bvalid,
  input  logic [0:0]        m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_bready,
  output logic [0:0]        m_axi_arid,
  output logic [31:0]       m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic              m_axi_rvalid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [0:0]        m_axi_rid,
  input  logic              m_axi_rlast,
  input  logic [1:0]        m_axi_rresp,
  output logic              m_axi_rready
);

  localparam int FW = DATA_W + KEEP_W + 1;

  logic clk;
  logic rst;
  assign clk = clk_250mhz;
  assign rst = clk_250mhz_rst;

  // AXI master parked
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = '0;
  assign m_axi_awlen   = '0;
  assign m_axi_awsize  = '0;
  assign m_axi_awburst = '0;
  assign m_axi_awvalid = 1'b0;
  assign m_axi_wdata   = '0;
  assign m_axi_wstrb   = '0;
  assign m_axi_wlast   = 1'b0;
  assign m_axi_wvalid  = 1'b0;
  assign m_axi_bready  = 1'b1;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = '0;
  assign m_axi_arlen   = '0;
  assign m_axi_arsize  = '0;
  assign m_axi_arburst = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b1;

  logic unused_axi;
  assign unused_axi = ^{m_axi_awready, m_axi_wready,
                        m_axi_bvalid, m_axi_bid, m_axi_bresp,
                        m_axi_arready, m_axi_rvalid, m_axi_rdata,
                        m_axi_rid, m_axi_rlast, m_axi_rresp};

  assign m_axis_net_tx_tdest             = 1'b0;
  assign m_axis_net_tx_to_endpoint_tdest = 1'b0;

  // ---------------- TX path ----------------
  tx_state_t         tx_state;
  tx_state_t         tx_next;
  logic [31:0]       seq;
  logic [31:0]       ack;
  logic [31:0]       tx_bytes;
  logic [FW-1:0]     head;
  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [KEEP_W-1:0] head_keep;
  logic              head_last;
  logic [6:0]        head_pc;
  logic              tx_pop;
  logic [DATA_W-1:0] hdr;

  snic_axis_fifo #(
    .W  (FW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_data  ({s_axis_net_rx_from_endpoint_tdata,
                  s_axis_net_rx_from_endpoint_tkeep,
                  s_axis_net_rx_from_endpoint_tlast}),
    .push_valid (s_axis_net_rx_from_endpoint_tvalid),
    .push_ready (s_axis_net_rx_from_endpoint_tready),
    .pop_data   (head),
    .pop_valid  (head_valid),
    .pop_ready  (tx_pop)
  );

  assign {head_data, head_keep, head_last} = head;
  assign head_pc = popcount64(head_keep);

  always_comb begin
    hdr = '0;
    hdr = put_be(hdr, OFF_DST_MAC, 6, REM_MAC);
    hdr = put_be(hdr, OFF_SRC_MAC, 6, LOC_MAC);
    hdr = put_be(hdr, OFF_ETYPE, 2, 48'(ETHERTYPE_IPV4));
    hdr = put_be(hdr, OFF_VER_IHL, 1, 48'(IP_VER_IHL));
    hdr = put_be(hdr, OFF_TTL, 1, 48'(IP_TTL));
    hdr = put_be(hdr, OFF_PROTO, 1, 48'(IP_PROTO_TCP));
    hdr = put_be(hdr, OFF_SIP, 4, 48'(LOC_IP));
    hdr = put_be(hdr, OFF_DIP, 4, 48'(REM_IP));
    hdr = put_be(hdr, OFF_SPORT, 2, 48'(LOC_PORT));
    hdr = put_be(hdr, OFF_DPORT, 2, 48'(REM_PORT));
    hdr = put_be(hdr, OFF_SEQ, 4, 48'(seq));
    hdr = put_be(hdr, OFF_ACK, 4, 48'(ack));
    hdr = put_be(hdr, OFF_DOFF, 1, 48'(TCP_DOFF));
    hdr = put_be(hdr, OFF_FLAGS, 1, 48'(TCP_FLAGS_PSH_ACK));
    hdr = put_be(hdr, OFF_WIN, 2, 48'(TCP_WIN));
  end

  always_comb begin
    tx_next              = tx_state;
    tx_pop               = 1'b0;
    m_axis_net_tx_tvalid = 1'b0;
    m_axis_net_tx_tdata  = '0;
    m_axis_net_tx_tkeep  = '0;
    m_axis_net_tx_tlast  = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (head_valid) tx_next = TX_HDR;
      end
      TX_HDR: begin
        m_axis_net_tx_tvalid = 1'b1;
        m_axis_net_tx_tdata  = hdr;
        m_axis_net_tx_tkeep  = '1;
        if (m_axis_net_tx_tready) tx_next = TX_PAY;
      end
      TX_PAY: begin
        m_axis_net_tx_tvalid = head_valid;
        m_axis_net_tx_tdata  = head_data;
        m_axis_net_tx_tkeep  = head_keep;
        m_axis_net_tx_tlast  = head_last;
        tx_pop               = m_axis_net_tx_tready;
        if (head_valid && m_axis_net_tx_tready && head_last)
          tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      seq      <= INIT_SEQ;
      tx_bytes <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_PAY && head_valid && m_axis_net_tx_tready) begin
        if (head_last) begin
          seq      <= seq + tx_bytes + 32'(head_pc);
          tx_bytes <= '0;
        end else begin
          tx_bytes <= tx_bytes + 32'(head_pc);
        end
      end
    end
  end

  // ---------------- RX path ----------------
  rx_state_t   rx_state;
  rx_state_t   rx_next;
  logic [31:0] rx_seq;
  logic [31:0] rx_bytes;
  logic        rx_match;
  logic        rx_acc;
  logic [6:0]  rx_pc;

  assign rx_match =
    get_be(s_axis_net_rx_tdata, OFF_ETYPE, 2) == 32'(ETHERTYPE_IPV4) &&
    get_be(s_axis_net_rx_tdata, OFF_PROTO, 1) == 32'(IP_PROTO_TCP) &&
    get_be(s_axis_net_rx_tdata, OFF_DIP, 4) == LOC_IP &&
    get_be(s_axis_net_rx_tdata, OFF_DPORT, 2) == 32'(LOC_PORT);

  assign rx_acc = s_axis_net_rx_tvalid && s_axis_net_rx_tready;
  assign rx_pc  = popcount64(s_axis_net_rx_tkeep);

  always_comb begin
    rx_next                          = rx_state;
    s_axis_net_rx_tready             = 1'b0;
    m_axis_net_tx_to_endpoint_tvalid = 1'b0;
    m_axis_net_tx_to_endpoint_tdata  = '0;
    m_axis_net_tx_to_endpoint_tkeep  = '0;
    m_axis_net_tx_to_endpoint_tlast  = 1'b0;
    unique case (rx_state)
      RX_HDR: begin
        s_axis_net_rx_tready = 1'b1;
        // a header flit carrying last is a payload-less packet
        if (s_axis_net_rx_tvalid && !s_axis_net_rx_tlast)
          rx_next = rx_match ? RX_FWD : RX_DROP;
      end
      RX_FWD: begin
        s_axis_net_rx_tready             = m_axis_net_tx_to_endpoint_tready;
        m_axis_net_tx_to_endpoint_tvalid = s_axis_net_rx_tvalid;
        m_axis_net_tx_to_endpoint_tdata  = s_axis_net_rx_tdata;
        m_axis_net_tx_to_endpoint_tkeep  = s_axis_net_rx_tkeep;
        m_axis_net_tx_to_endpoint_tlast  = s_axis_net_rx_tlast;
        if (rx_acc && s_axis_net_rx_tlast) rx_next = RX_HDR;
      end
      RX_DROP: begin
        s_axis_net_rx_tready = 1'b1;
        if (s_axis_net_rx_tvalid && s_axis_net_rx_tlast)
          rx_next = RX_HDR;
      end
      default: rx_next = RX_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_HDR;
      rx_seq   <= '0;
      rx_bytes <= '0;
      ack      <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_HDR && s_axis_net_rx_tvalid &&
          !s_axis_net_rx_tlast && rx_match) begin
        rx_seq   <= get_be(s_axis_net_rx_tdata, OFF_SEQ, 4);
        rx_bytes <= '0;
      end
      if (rx_state == RX_FWD && rx_acc) begin
        if (s_axis_net_rx_tlast) begin
          ack <= rx_seq + rx_bytes + 32'(rx_pc);
        end else begin
          rx_bytes <= rx_bytes + 32'(rx_pc);
        end
      end
    end
  end

endmodule

// File: tb/tb_snic_tcp_design.sv
// Self-checking bench for snic_tcp_design: randomized TX/RX traffic
// against a queue-based reference model of headers, seq and ack.
module tb_snic_tcp_design;

  localparam logic [47:0] LOC_MAC  = 48'h000A35000001;
  localparam logic [47:0] REM_MAC  = 48'h000A35000002;
  localparam logic [31:0] LOC_IP   = 32'h0A000001;
  localparam logic [31:0] REM_IP   = 32'h0A000002;
  localparam logic [15:0] LOC_PORT = 16'd5001;
  localparam logic [15:0] REM_PORT = 16'd5002;
  localparam int          BOUND    = 200;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [511:0] ep_d = '0;
  logic [63:0]  ep_k = '0;
  logic         ep_l = 1'b0;
  logic         ep_v = 1'b0;
  logic         ep_r;
  logic [511:0] tx_d;
  logic [63:0]  tx_k;
  logic         tx_l, tx_v, tx_dest;
  logic         tx_r = 1'b0;
  logic [511:0] rx_d = '0;
  logic [63:0]  rx_k = '0;
  logic         rx_l = 1'b0;
  logic         rx_v = 1'b0;
  logic         rx_r;
  logic [511:0] eo_d;
  logic [63:0]  eo_k;
  logic         eo_l, eo_v, eo_dest;
  logic         eo_r = 1'b0;

  logic [0:0]   awid, arid;
  logic [31:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst;
  logic         awvalid, wlast, wvalid, bready, arvalid, rready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;

  snic_tcp_design dut (
    .clk_250mhz                         (clk),
    .clk_250mhz_rst                     (rst),
    .s_axis_net_rx_from_endpoint_tdata  (ep_d),
    .s_axis_net_rx_from_endpoint_tkeep  (ep_k),
    .s_axis_net_rx_from_endpoint_tlast  (ep_l),
    .s_axis_net_rx_from_endpoint_tvalid (ep_v),
    .s_axis_net_rx_from_endpoint_tready (ep_r),
    .m_axis_net_tx_tdata                (tx_d),
    .m_axis_net_tx_tkeep                (tx_k),
    .m_axis_net_tx_tlast                (tx_l),
    .m_axis_net_tx_tvalid               (tx_v),
    .m_axis_net_tx_tdest                (tx_dest),
    .m_axis_net_tx_tready               (tx_r),
    .s_axis_net_rx_tdata                (rx_d),
    .s_axis_net_rx_tkeep                (rx_k),
    .s_axis_net_rx_tlast                (rx_l),
    .s_axis_net_rx_tvalid               (rx_v),
    .s_axis_net_rx_tready               (rx_r),
    .m_axis_net_tx_to_endpoint_tdata    (eo_d),
    .m_axis_net_tx_to_endpoint_tkeep    (eo_k),
    .m_axis_net_tx_to_endpoint_tlast    (eo_l),
    .m_axis_net_tx_to_endpoint_tvalid   (eo_v),
    .m_axis_net_tx_to_endpoint_tdest    (eo_dest),
    .m_axis_net_tx_to_endpoint_tready   (eo_r),
    .m_axi_awid    (awid),
    .m_axi_awaddr  (awaddr),
    .m_axi_awlen   (awlen),
    .m_axi_awsize  (awsize),
    .m_axi_awburst (awburst),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (1'b0),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wlast   (wlast),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (1'b0),
    .m_axi_bvalid  (1'b0),
    .m_axi_bid     (1'b0),
    .m_axi_bresp   (2'b00),
    .m_axi_bready  (bready),
    .m_axi_arid    (arid),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arburst (arburst),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (1'b0),
    .m_axi_rvalid  (1'b0),
    .m_axi_rdata   ('0),
    .m_axi_rid     (1'b0),
    .m_axi_rlast   (1'b0),
    .m_axi_rresp   (2'b00),
    .m_axi_rready  (rready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_tx_acc = 0;
  int n_pushed = 0;
  int tx_mode = 1;
  int eo_mode = 1;
  bit gaps = 0;
  bit abort = 0;
  bit tx_busy = 0;
  logic [31:0] seq_m = 32'h0;
  logic [31:0] ack_m = 32'h0;
  flit_t exp_tx[$];
  flit_t exp_ep[$];
  int    tx_t[$];
  flit_t mt, me;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0: tx_r = 1'b0;
      1: tx_r = 1'b1;
      default: tx_r = ($urandom % 4) != 0;
    endcase
    case (eo_mode)
      0: eo_r = 1'b0;
      1: eo_r = 1'b1;
      default: eo_r = ($urandom % 4) != 0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && tx_v && tx_r) begin
      n_tx_acc++;
      tx_t.push_back(cyc);
      if (exp_tx.size() == 0) begin
        chk("tx_unexpected", 512'(tx_v), 512'(0));
      end else begin
        mt = exp_tx.pop_front();
        chk("tx_data", tx_d, mt.d);
        chk("tx_keep", 512'(tx_k), 512'(mt.k));
        chk("tx_last", 512'(tx_l), 512'(mt.l));
        chk("tx_dest", 512'(tx_dest), 512'(0));
      end
    end
    if (!rst && eo_v && eo_r) begin
      if (exp_ep.size() == 0) begin
        chk("ep_unexpected", 512'(eo_v), 512'(0));
      end else begin
        me = exp_ep.pop_front();
        chk("ep_data", eo_d, me.d);
        chk("ep_keep", 512'(eo_k), 512'(me.k));
        chk("ep_last", 512'(eo_l), 512'(me.l));
        chk("ep_dest", 512'(eo_dest), 512'(0));
      end
    end
  end

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] keep_n(input int nb);
    logic [63:0] k;
    for (int i = 0; i < 64; i++) k[i] = (i < nb);
    return k;
  endfunction

  function automatic logic [511:0] pack(input logic [7:0] b [64]);
    logic [511:0] d;
    for (int n = 0; n < 64; n++) d[8*n +: 8] = b[n];
    return d;
  endfunction

  function automatic logic [511:0] mk_tx_hdr(input logic [31:0] s,
                                             input logic [31:0] a);
    logic [7:0] b [64];
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i]     = 8'(REM_MAC >> (8*(5-i)));
      b[6 + i] = 8'(LOC_MAC >> (8*(5-i)));
    end
    b[12] = 8'h08;
    b[14] = 8'h45;
    b[22] = 8'h40;
    b[23] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      b[26 + i] = 8'(LOC_IP >> (8*(3-i)));
      b[30 + i] = 8'(REM_IP >> (8*(3-i)));
      b[38 + i] = 8'(s >> (8*(3-i)));
      b[42 + i] = 8'(a >> (8*(3-i)));
    end
    b[34] = LOC_PORT[15:8];
    b[35] = LOC_PORT[7:0];
    b[36] = REM_PORT[15:8];
    b[37] = REM_PORT[7:0];
    b[46] = 8'h50;
    b[47] = 8'h18;
    b[48] = 8'hFF;
    b[49] = 8'hFF;
    return pack(b);
  endfunction

  function automatic logic [511:0] mk_rx_hdr(
    input logic [15:0] et, input logic [7:0] pr,
    input logic [31:0] dip, input logic [15:0] dport,
    input logic [31:0] s);
    logic [7:0] b [64];
    logic [511:0] r;
    r = rand512();
    for (int i = 0; i < 64; i++) b[i] = r[8*i +: 8];
    b[12] = et[15:8];
    b[13] = et[7:0];
    b[23] = pr;
    for (int i = 0; i < 4; i++) begin
      b[30 + i] = 8'(dip >> (8*(3-i)));
      b[38 + i] = 8'(s >> (8*(3-i)));
    end
    b[36] = dport[15:8];
    b[37] = dport[7:0];
    return pack(b);
  endfunction

  task automatic put_ep(input flit_t f);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    ep_d = f.d;
    ep_k = f.k;
    ep_l = f.l;
    ep_v = 1'b1;
    while (!ok && n < BOUND && !abort) begin
      @(negedge clk);
      ok = ep_r;
      @(posedge clk);
      #1;
      n++;
    end
    ep_v = 1'b0;
    if (ok) n_pushed++;
    else if (!abort) chk("ep_in_timeout", 512'(ok), 512'(1));
  endtask

  task automatic put_rx(input flit_t f);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    rx_d = f.d;
    rx_k = f.k;
    rx_l = f.l;
    rx_v = 1'b1;
    while (!ok && n < BOUND) begin
      @(negedge clk);
      ok = rx_r;
      @(posedge clk);
      #1;
      n++;
    end
    rx_v = 1'b0;
    if (!ok) chk("rx_in_timeout", 512'(ok), 512'(1));
  endtask

  task automatic send_tx(input int nf, input int lastb);
    flit_t f;
    flit_t q[$];
    int bytes;
    bytes = 0;
    tx_busy = 1;
    f.d = mk_tx_hdr(seq_m, ack_m);
    f.k = '1;
    f.l = 1'b0;
    exp_tx.push_back(f);
    for (int i = 0; i < nf; i++) begin
      f.d = rand512();
      f.l = (i == nf - 1);
      f.k = f.l ? keep_n(lastb) : '1;
      bytes += f.l ? lastb : 64;
      q.push_back(f);
      exp_tx.push_back(f);
    end
    seq_m = seq_m + 32'(bytes);
    foreach (q[i]) begin
      if (abort) break;
      if (gaps && ($urandom % 4) == 0) begin
        @(posedge clk);
        #1;
      end
      put_ep(q[i]);
    end
    tx_busy = 0;
  endtask

  task automatic send_rx(input logic [15:0] et, input logic [7:0] pr,
                         input logic [31:0] dip, input logic [15:0] dport,
                         input int np, input int lastb);
    flit_t f;
    flit_t q[$];
    logic [31:0] s;
    bit match;
    int bytes;
    bytes = 0;
    s = $urandom;
    match = (et == 16'h0800) && (pr == 8'h06) &&
            (dip == LOC_IP) && (dport == LOC_PORT);
    f.d = mk_rx_hdr(et, pr, dip, dport, s);
    f.k = '1;
    f.l = (np == 0);
    q.push_back(f);
    for (int i = 0; i < np; i++) begin
      f.d = rand512();
      f.l = (i == np - 1);
      f.k = f.l ? keep_n(lastb) : '1;
      bytes += f.l ? lastb : 64;
      q.push_back(f);
      if (match) exp_ep.push_back(f);
    end
    if (match && np > 0) ack_m = s + 32'(bytes);
    foreach (q[i]) begin
      if (gaps && ($urandom % 4) == 0) begin
        @(posedge clk);
        #1;
      end
      put_rx(q[i]);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tx.size() + exp_ep.size()) > 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 512'(exp_tx.size() + exp_ep.size()), 512'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < BOUND * 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tx_busy_timeout", 512'(tx_busy), 512'(0));
  endtask

  initial begin
    int n;
    int pick;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_tx_valid", 512'(tx_v), 512'(0));
    chk("rst_tx_last", 512'(tx_l), 512'(0));
    chk("rst_tx_dest", 512'(tx_dest), 512'(0));
    chk("rst_ep_valid", 512'(eo_v), 512'(0));
    chk("rst_ep_last", 512'(eo_l), 512'(0));
    chk("rst_ep_dest", 512'(eo_dest), 512'(0));
    chk("rst_in_ready", 512'(ep_r), 512'(1));
    chk("rst_rx_ready", 512'(rx_r), 512'(1));
    chk("axi_ctl_zero", 512'({awid, awaddr, awlen, awsize, awburst,
        awvalid, wstrb, wlast, wvalid, arid, araddr, arlen, arsize,
        arburst, arvalid}), 512'(0));
    chk("axi_wdata_zero", wdata, 512'(0));
    chk("axi_b_r_ready", 512'({bready, rready}), 512'(3));

    // single full flit, then header seq must reflect 64
    tx_mode = 1;
    eo_mode = 1;
    gaps = 0;
    send_tx(1, 64);
    drain();

    // 3 flits back-to-back: 4 contiguous output flits
    tx_t.delete();
    send_tx(3, 64);
    drain();
    chk("tx_cnt_3", 512'(tx_t.size()), 512'(4));
    if (tx_t.size() == 4)
      chk("tx_contig", 512'(tx_t[3] - tx_t[0]), 512'(3));

    // backpressure on a 12-flit burst: FIFO fills at 8
    tx_mode = 0;
    n_pushed = 0;
    fork
      send_tx(12, 64);
    join_none
    repeat (20) @(posedge clk);
    #1;
    chk("in_ready_full", 512'(ep_r), 512'(0));
    chk("fifo_fill", 512'(n_pushed), 512'(8));
    tx_mode = 1;
    wait_idle();
    drain();

    // matching RX then TX header carries new ack
    send_rx(16'h0800, 8'h06, LOC_IP, LOC_PORT, 2, 64);
    drain();
    send_tx(1, 64);
    drain();

    // wrong dst IP: dropped, ack unchanged
    send_rx(16'h0800, 8'h06, 32'h0A0000FF, LOC_PORT, 3, 17);
    drain();
    send_tx(1, 20);
    drain();

    // matching header-only packet: nothing forwarded, ack unchanged
    send_rx(16'h0800, 8'h06, LOC_IP, LOC_PORT, 0, 64);
    drain();
    send_tx(2, 1);
    drain();

    // randomized mix
    tx_mode = 2;
    eo_mode = 2;
    gaps = 1;
    for (int it = 0; it < 40; it++) begin
      pick = $urandom_range(0, 5);
      if (pick < 2) begin
        send_tx($urandom_range(1, 5), $urandom_range(1, 64));
      end else if (pick < 4) begin
        send_rx(16'h0800, 8'h06, LOC_IP, LOC_PORT,
                $urandom_range(0, 3), $urandom_range(1, 64));
      end else begin
        case ($urandom_range(0, 3))
          0: send_rx(16'h86DD, 8'h06, LOC_IP, LOC_PORT,
                     $urandom_range(0, 3), $urandom_range(1, 64));
          1: send_rx(16'h0800, 8'h11, LOC_IP, LOC_PORT,
                     $urandom_range(0, 3), $urandom_range(1, 64));
          2: send_rx(16'h0800, 8'h06, LOC_IP, 16'd7777,
                     $urandom_range(0, 3), $urandom_range(1, 64));
          default: send_rx(16'h0800, 8'h06, REM_IP, LOC_PORT,
                           $urandom_range(0, 3), $urandom_range(1, 64));
        endcase
      end
      drain();
    end
    send_tx(1, 64);
    drain();

    // reset in the middle of a TX payload
    tx_mode = 1;
    eo_mode = 1;
    gaps = 0;
    n_tx_acc = 0;
    fork
      send_tx(5, 64);
    join_none
    n = 0;
    while (n_tx_acc < 2 && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pay_reached", 512'(n_tx_acc >= 2), 512'(1));
    chk("pay_valid", 512'(tx_v), 512'(1));
    rst = 1'b1;
    abort = 1'b1;
    #1;
    chk("async_rst_tx_valid", 512'(tx_v), 512'(0));
    chk("async_rst_ep_valid", 512'(eo_v), 512'(0));
    wait_idle();
    exp_tx.delete();
    exp_ep.delete();
    seq_m = 32'h0;
    ack_m = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    abort = 1'b0;
    send_tx(1, 64);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
